// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, MIPS opcode
// constants, instruction field positions and an immediate sign-extension helper.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;

    function automatic logic [31:0] sext16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch or fall-through.
// Jump takes priority over branch; all arithmetic wraps modulo 2^32.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic        branch,
    input  logic        jump,
    input  logic        alu_zero,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [5:0]  unused_opcode;

    assign unused_opcode = ir[OPCODE_MSB:OPCODE_LSB];

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + (sext16(ir[IMM_MSB:IMM_LSB]) << 2);
    // Jump keeps the 256 MB region of the delay-slot address, not of the jump itself.
    assign jump_target   = {pc_plus4[31:28], ir[TARGET_MSB:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && alu_zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds PC, requests words from imem, latches IR and presents decoded fields.
// Optional IF_BUSERR_EN adds imem_err/exc_flag and redirects to EXC_VEC on a bus error.
module instr_fetch_unit
    import mips_pkg::*;
#(
`ifdef IF_BUSERR_EN
    parameter logic [31:0] EXC_VEC   = 32'h0000_0080,
`endif
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
`ifdef IF_BUSERR_EN
    input  logic        imem_err,
    output logic        exc_flag,
`endif
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        jump,
    input  logic        alu_zero
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  ir_reg, ir_next;
    logic [31:0]  next_pc;
`ifdef IF_BUSERR_EN
    logic         exc_flag_reg, exc_flag_next;
`endif

    next_pc_calc u_next_pc (
        .pc       (pc_reg),
        .ir       (ir_reg),
        .branch   (branch),
        .jump     (jump),
        .alu_zero (alu_zero),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_VEC;
            ir_reg       <= '0;
`ifdef IF_BUSERR_EN
            exc_flag_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
`ifdef IF_BUSERR_EN
            exc_flag_reg <= exc_flag_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        imem_req      = 1'b0;
        instr_valid   = 1'b0;
`ifdef IF_BUSERR_EN
        exc_flag_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
`ifdef IF_BUSERR_EN
                    // A faulted fetch never reaches decode: IR becomes a nop and PC redirects.
                    if (imem_err) begin
                        ir_next       = '0;
                        pc_next       = EXC_VEC;
                        exc_flag_next = 1'b1;
                        state_next    = REQ;
                    end else begin
                        ir_next    = imem_rdata;
                        state_next = VALID;
                    end
`else
                    ir_next    = imem_rdata;
                    state_next = VALID;
`endif
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    pc_next    = next_pc;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_addr = pc_reg;
    assign opcode    = ir_reg[OPCODE_MSB:OPCODE_LSB];
    assign funct     = ir_reg[FUNCT_MSB:FUNCT_LSB];
    assign rs        = ir_reg[RS_MSB:RS_LSB];
    assign rt        = ir_reg[RT_MSB:RT_LSB];
    assign rd        = ir_reg[RD_MSB:RD_LSB];
    assign imm       = ir_reg[IMM_MSB:IMM_LSB];
`ifdef IF_BUSERR_EN
    assign exc_flag  = exc_flag_reg;
`endif

endmodule
